// File: rtl/spmv_mem_resp_pkg.sv
// Shared types and widths for the SpMV memory-response block.
// A request entry carries both strobes so the arbiter can tell loads from stores at the head.
package spmv_mem_resp_pkg;

    localparam int unsigned ADDR_W = 48;
    localparam int unsigned DATA_W = 64;

    typedef struct packed {
        logic              ld;
        logic              st;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] d_or_tag;
    } req_t;

    localparam int unsigned REQ_W = $bits(req_t);

endpackage

// File: rtl/spmv_sync_fifo.sv
// Synchronous FIFO with occupancy count, used for request and response queues.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module spmv_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/spmv_mem_resp.sv
// Multi-channel PE memory model: per-channel request FIFOs, round-robin grant to a shared RAM,
// fixed-latency load pipeline and per-channel response FIFOs with registered outputs.
module spmv_mem_resp
    import spmv_mem_resp_pkg::*;
#(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned REQ_DEPTH = 4,
    parameter int unsigned RSP_DEPTH = 8,
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned TAG_W     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          req_mem_ld,
    input  logic [N_CH-1:0]          req_mem_st,
    input  logic [N_CH*ADDR_W-1:0]   req_mem_addr,
    input  logic [N_CH*DATA_W-1:0]   req_mem_d_or_tag,
    output logic [N_CH-1:0]          req_mem_stall,
    output logic [N_CH-1:0]          rsp_mem_push,
    output logic [N_CH*TAG_W-1:0]    rsp_mem_tag,
    output logic [N_CH*DATA_W-1:0]   rsp_mem_q,
    input  logic [N_CH-1:0]          rsp_mem_stall,
    output logic                     err
);

    localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned WORD_W   = ADDR_W - 3;
    localparam int unsigned RQ_CNT_W = $clog2(REQ_DEPTH + 1);
    localparam int unsigned RS_CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned RSP_W    = TAG_W + DATA_W;

    typedef struct packed {
        logic              valid;
        logic [CH_W-1:0]   ch;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } pipe_t;

    req_t              req_in   [N_CH];
    req_t              req_head [N_CH];
    logic [N_CH-1:0]   eligible;
    logic              gnt_valid;
    logic [CH_W-1:0]   gnt_ch, cand, ptr_q;
    req_t              gnt_req;
    logic [WORD_W-1:0] gnt_word;
    logic              in_range;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] mem [MEM_WORDS];
    pipe_t             pipe_in, pipe_out;
    logic              err_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic                rq_push, rq_pop, rq_empty, rq_full;
        logic [RQ_CNT_W-1:0] rq_count;
        logic                stall_q;
        logic                ld_gnt, rs_push, rs_pop, rs_empty, rs_full;
        logic [RS_CNT_W-1:0] rs_count, out_cnt_q;
        logic [RSP_W-1:0]    rs_head;
        logic                push_q;
        logic [TAG_W-1:0]    tag_q;
        logic [DATA_W-1:0]   q_q;
        logic                unused_fifo;

        assign req_in[c] = '{ld: req_mem_ld[c], st: req_mem_st[c],
                             addr: req_mem_addr[c*ADDR_W +: ADDR_W],
                             d_or_tag: req_mem_d_or_tag[c*DATA_W +: DATA_W]};
        // Conflicting strobes are never queued; err records them.
        assign rq_push = req_mem_ld[c] ^ req_mem_st[c];
        assign rq_pop  = gnt_valid && (gnt_ch == CH_W'(c));

        spmv_sync_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (rq_push),
            .wdata (req_in[c]),
            .pop   (rq_pop),
            .rdata (req_head[c]),
            .full  (rq_full),
            .empty (rq_empty),
            .count (rq_count)
        );

        // Outstanding loads cover pipeline plus response FIFO, so the FIFO can never overflow.
        assign eligible[c] = ~rq_empty & (req_head[c].st | (out_cnt_q < RS_CNT_W'(RSP_DEPTH)));
        assign ld_gnt      = rq_pop & req_head[c].ld;
        assign rs_push     = pipe_out.valid && (pipe_out.ch == CH_W'(c));
        assign rs_pop      = ~rs_empty & ~rsp_mem_stall[c];

        spmv_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (rs_push),
            .wdata ({pipe_out.tag, pipe_out.data}),
            .pop   (rs_pop),
            .rdata (rs_head),
            .full  (rs_full),
            .empty (rs_empty),
            .count (rs_count)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stall_q   <= 1'b0;
                out_cnt_q <= '0;
                push_q    <= 1'b0;
                tag_q     <= '0;
                q_q       <= '0;
            end else begin
                stall_q <= (rq_count >= RQ_CNT_W'(REQ_DEPTH - 2));
                if (ld_gnt && !rs_pop) begin
                    out_cnt_q <= out_cnt_q + RS_CNT_W'(1);
                end else if (!ld_gnt && rs_pop) begin
                    out_cnt_q <= out_cnt_q - RS_CNT_W'(1);
                end
                push_q <= rs_pop;
                tag_q  <= rs_pop ? rs_head[RSP_W-1 -: TAG_W] : '0;
                q_q    <= rs_pop ? rs_head[DATA_W-1:0] : '0;
            end
        end

        assign req_mem_stall[c]                = stall_q;
        assign rsp_mem_push[c]                 = push_q;
        assign rsp_mem_tag[c*TAG_W +: TAG_W]   = tag_q;
        assign rsp_mem_q[c*DATA_W +: DATA_W]   = q_q;
        assign unused_fifo = ^{rq_full, rs_full, rs_count};
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_ch    = '0;
        cand      = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            cand = CH_W'((int'(ptr_q) + k) % int'(N_CH));
            if (!gnt_valid && eligible[cand]) begin
                gnt_valid = 1'b1;
                gnt_ch    = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (gnt_valid) begin
            ptr_q <= (gnt_ch == CH_W'(N_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
        end
    end

    assign gnt_req  = req_head[gnt_ch];
    assign gnt_word = gnt_req.addr[ADDR_W-1:3];
    assign in_range = (gnt_word < WORD_W'(MEM_WORDS));
    assign rd_data  = in_range ? mem[gnt_word[IDX_W-1:0]] : '0;

    // RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (gnt_valid && gnt_req.st && in_range) mem[gnt_word[IDX_W-1:0]] <= gnt_req.d_or_tag;
    end

    assign pipe_in = '{valid: gnt_valid & gnt_req.ld, ch: gnt_ch,
                       tag: gnt_req.d_or_tag[TAG_W-1:0], data: rd_data};

    if (LATENCY == 1) begin : g_lat1
        assign pipe_out = pipe_in;
    end else begin : g_pipe
        pipe_t stage_q [LATENCY-1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(LATENCY) - 1; i++) stage_q[i] <= '0;
            end else begin
                stage_q[0] <= pipe_in;
                for (int i = 1; i < int'(LATENCY) - 1; i++) stage_q[i] <= stage_q[i-1];
            end
        end
        assign pipe_out = stage_q[LATENCY-2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((|(req_mem_ld & req_mem_st)) || (gnt_valid && !in_range)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

    logic unused_addr;
    assign unused_addr = ^gnt_req.addr[2:0];

endmodule

// File: doc/spmv_mem_resp.md
SPMV_MEM_RESP -- requirements
Module: spmv_mem_resp

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N_CH, 2, number of PE memory channels
- LATENCY, 4, grant-to-response-FIFO cycles for loads (>=1)
- REQ_DEPTH, 4, per-channel request FIFO entries (>=3)
- RSP_DEPTH, 8, per-channel response FIFO entries
- MEM_WORDS, 4096, 64-bit words of backing store
- TAG_W, 3, load tag width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock
- rst_n, in, 1, asynchronous active-low reset
- req_mem_ld, in, N_CH, per-channel load strobe
- req_mem_st, in, N_CH, per-channel store strobe
- req_mem_addr, in, N_CH*48, byte address
- req_mem_d_or_tag, in, N_CH*64, store data, or load tag in [TAG_W-1:0]
- req_mem_stall, out, N_CH, registered back-pressure to PE
- rsp_mem_push, out, N_CH, registered response valid
- rsp_mem_tag, out, N_CH*TAG_W, returned tag
- rsp_mem_q, out, N_CH*64, returned data
- rsp_mem_stall, in, N_CH, PE cannot take a response this cycle
- err, out, 1, sticky protocol/range error

Function
REQ-003 A strobe SHALL be accepted into channel c's request FIFO in the cycle it is high; the PE issues nothing while req_mem_stall[c]=1.
REQ-004 req_mem_stall[c] SHALL be registered and high when the request FIFO occupancy is >= REQ_DEPTH-2, so that one in-flight request is absorbed without overflow.
REQ-005 When ld and st are both high on one channel, the request SHALL be discarded and err set.
REQ-006 One round-robin arbiter SHALL grant at most one head request per cycle. The pointer starts at channel 0 after reset and moves to granted+1.
REQ-007 A load head SHALL be eligible only if outstanding loads (pipeline plus response FIFO) < RSP_DEPTH. A store head SHALL always be eligible.
REQ-008 Word index SHALL be addr[47:3]. Address bits [2:0] are ignored.
REQ-009 A granted store SHALL write the RAM in the grant cycle.
REQ-010 A granted load SHALL read the RAM in the grant cycle and enter the response FIFO exactly LATENCY cycles later. A load granted one cycle after a store to the same word SHALL return the new data.
REQ-011 A word index >= MEM_WORDS SHALL set err. A store to it SHALL be dropped. A load from it SHALL return data 0 with its tag.
REQ-012 The response FIFO SHALL pop when non-empty and rsp_mem_stall[c]=0. The popped entry SHALL appear on rsp_mem_push/tag/q the next cycle.
REQ-013 When rsp_mem_push[c]=0, rsp_mem_tag and rsp_mem_q SHALL be 0.
REQ-014 Responses SHALL be in request order per channel. There is no ordering between channels.
REQ-015 Simultaneous FIFO push and pop SHALL leave occupancy unchanged, including when the FIFO is full.

Reset
REQ-016 While rst_n=0, all FIFOs and the pipeline SHALL empty and the arbiter pointer SHALL be 0.
REQ-017 While rst_n=0, req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q and err SHALL be 0.
REQ-018 RAM contents SHALL be unaffected by reset.
REQ-019 A reset asserted mid-operation SHALL drop all in-flight loads with no response after release.

Structure
REQ-020 A shared package SHALL hold ADDR_W=48, DATA_W=64 and the request-entry typedef {ld, st, addr, d_or_tag}.
REQ-021 A single parametrised sub-module, spmv_sync_fifo (width, depth, full/empty/count), SHALL be instanced for both the request and response FIFOs.

Verification
REQ-022 Single channel, LATENCY=4: store 0x3FF0000000000000 to addr 0x40, then load addr 0x40 with tag 5 -> exactly one push with tag=5 and q=0x3FF0000000000000, 4+1 cycles after grant.
REQ-023 Two channels load every cycle -> grants alternate 0,1,0,1; each channel receives exactly 50% of responses; no FIFO overflow.
REQ-024 Hold rsp_mem_stall[0]=1 with RSP_DEPTH=8 -> after 8 loads channel 0 is no longer granted and req_mem_stall[0] rises. Release -> 8 in-order responses, then remaining requests drain.
REQ-025 Load addr MEM_WORDS*8 -> response q=0 with its tag and err=1. A store to that address leaves all RAM words unchanged.
REQ-026 Assert rst_n=0 with 3 loads in flight -> outputs 0 within the same cycle, and no response after release.
REQ-027 ld and st both high on channel 1 -> no RAM write, no response, err=1.
